// File: rtl/wav_sample_assembler.sv
// wav_sample_assembler
//   Turns the byte-serial WAV data-chunk payload into whole signed PCM samples,
//   one per valid/ready handshake, tagged with a channel index.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   byte_in/valid/ready  payload byte stream from the header parser
//   data_start           level, high during the audio data phase
//   bit_depth            bits per sample (8/16/24/32 supported)
//   num_channels         channel count (1..16 supported)
//   data_bytes           data-chunk length in bytes
//   sample_out           signed sample, MSB-aligned, PCM_WIDTH bits
//   sample_channel       channel index of sample_out
//   sample_valid/ready   output sample handshake
//   format_unsupported   header format cannot be handled
//   done                 whole data chunk consumed
//   sample_count         samples handed off in the current data phase
module wav_sample_assembler #(
  parameter int PCM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic                 data_start,
  input  logic [15:0]          bit_depth,
  input  logic [15:0]          num_channels,
  input  logic [31:0]          data_bytes,
  output logic [PCM_WIDTH-1:0] sample_out,
  output logic [3:0]           sample_channel,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 format_unsupported,
  output logic                 done,
  output logic [31:0]          sample_count
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCollect = 3'd1;
  localparam logic [2:0] StHold    = 3'd2;
  localparam logic [2:0] StDone    = 3'd3;
  localparam logic [2:0] StError   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [1:0]           bps_m1_q, bps_m1_d;    // bytes per sample minus one
  logic [3:0]           nch_m1_q, nch_m1_d;    // channels minus one
  logic [31:0]          remaining_q, remaining_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [23:0]          asm_q, asm_d;          // lower bytes; the last byte comes from byte_in
  logic [PCM_WIDTH-1:0] sample_q, sample_d;
  logic [3:0]           chan_q, chan_d;
  logic [31:0]          count_q, count_d;

  logic [31:0] word;
  logic        header_ok;

  // Left-justified 32-bit word formed when the final byte of a sample arrives.
  always_comb begin
    unique case (bps_m1_q)
      2'd0:    word = {byte_in ^ 8'h80, 24'h000000};
      2'd1:    word = {byte_in, asm_q[7:0], 16'h0000};
      2'd2:    word = {byte_in, asm_q[15:0], 8'h00};
      default: word = {byte_in, asm_q[23:0]};
    endcase
  end

  assign header_ok = ((bit_depth == 16'd8) || (bit_depth == 16'd16) ||
                      (bit_depth == 16'd24) || (bit_depth == 16'd32)) &&
                     (num_channels != 16'd0) && (num_channels <= 16'd16);

  always_comb begin
    state_d     = state_q;
    bps_m1_d    = bps_m1_q;
    nch_m1_d    = nch_m1_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    sample_d    = sample_q;
    chan_d      = chan_q;
    count_d     = count_q;

    unique case (state_q)
      StIdle: begin
        if (data_start) begin
          // 8->0, 16->1, 24->2, 32->3 (bits 4:3 minus one, mod 4)
          bps_m1_d    = bit_depth[4:3] - 2'd1;
          nch_m1_d    = num_channels[3:0] - 4'd1;
          remaining_d = data_bytes;
          count_d     = 32'd0;
          chan_d      = 4'd0;
          byte_idx_d  = 2'd0;
          asm_d       = 24'h0;
          if (!header_ok)               state_d = StError;
          else if (data_bytes == 32'd0) state_d = StDone;
          else                          state_d = StCollect;
        end
      end

      StCollect: begin
        if (!data_start) begin
          byte_idx_d = 2'd0;
          asm_d      = 24'h0;
          state_d    = StIdle;
        end else if (byte_valid) begin
          remaining_d = remaining_q - 32'd1;
          if (byte_idx_q == bps_m1_q) begin
            sample_d   = word[31 -: PCM_WIDTH];
            byte_idx_d = 2'd0;
            asm_d      = 24'h0;
            state_d    = StHold;
          end else begin
            unique case (byte_idx_q)
              2'd0:    asm_d[7:0]   = byte_in;
              2'd1:    asm_d[15:8]  = byte_in;
              default: asm_d[23:16] = byte_in;
            endcase
            if (remaining_q == 32'd1) begin
              // Chunk ends mid-sample: drop the partial sample.
              byte_idx_d = 2'd0;
              asm_d      = 24'h0;
              state_d    = StDone;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end
      end

      StHold: begin
        if (sample_ready) begin
          count_d = count_q + 32'd1;
          chan_d  = (chan_q == nch_m1_q) ? 4'd0 : chan_q + 4'd1;
        end
        if (!data_start)                state_d = StIdle;
        else if (sample_ready) begin
          if (remaining_q == 32'd0)     state_d = StDone;
          else                          state_d = StCollect;
        end
      end

      StDone: begin
        if (!data_start) state_d = StIdle;
      end

      StError: begin
        if (!data_start) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bps_m1_q    <= 2'd0;
      nch_m1_q    <= 4'd0;
      remaining_q <= 32'd0;
      byte_idx_q  <= 2'd0;
      asm_q       <= 24'h0;
      sample_q    <= '0;
      chan_q      <= 4'd0;
      count_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      bps_m1_q    <= bps_m1_d;
      nch_m1_q    <= nch_m1_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      sample_q    <= sample_d;
      chan_q      <= chan_d;
      count_q     <= count_d;
    end
  end

  // Pure decodes of the state register: no path from sample_ready to byte_ready.
  assign byte_ready         = (state_q == StCollect) || (state_q == StError);
  assign sample_valid       = (state_q == StHold);
  assign done               = (state_q == StDone);
  assign format_unsupported = (state_q == StError);
  assign sample_out         = sample_q;
  assign sample_channel     = chan_q;
  assign sample_count       = count_q;

endmodule

// File: tb/tb_wav_sample_assembler.sv
// Testbench for wav_sample_assembler: two instances (32-bit and 16-bit PCM
// output) share one stimulus stream and are compared every cycle against a
// transaction-level model of the data phase.
module tb_wav_sample_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        data_start;
  logic [15:0] bit_depth;
  logic [15:0] num_channels;
  logic [31:0] data_bytes;
  logic        sample_ready;

  logic        br32, sv32, fu32, dn32;
  logic [31:0] so32, sc32;
  logic [3:0]  ch32;
  logic        br16, sv16, fu16, dn16;
  logic [15:0] so16;
  logic [31:0] sc16;
  logic [3:0]  ch16;

  always #5 clk = ~clk;

  wav_sample_assembler #(.PCM_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(br32), .data_start(data_start), .bit_depth(bit_depth),
    .num_channels(num_channels), .data_bytes(data_bytes), .sample_out(so32),
    .sample_channel(ch32), .sample_valid(sv32), .sample_ready(sample_ready),
    .format_unsupported(fu32), .done(dn32), .sample_count(sc32)
  );

  wav_sample_assembler #(.PCM_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(br16), .data_start(data_start), .bit_depth(bit_depth),
    .num_channels(num_channels), .data_bytes(data_bytes), .sample_out(so16),
    .sample_channel(ch16), .sample_valid(sv16), .sample_ready(sample_ready),
    .format_unsupported(fu16), .done(dn16), .sample_count(sc16)
  );

  int vectors = 0;
  int miscompares = 0;

  localparam int MIdle = 0, MCollect = 1, MHold = 2, MDone = 3, MError = 4;

  // Model of the data phase
  int          m_state;
  int          m_bps, m_nch, m_rem, m_count;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_out32;
  logic [15:0] m_out16;

  logic [7:0]  feed[$];        // bytes waiting to be offered
  logic [31:0] log32[$];       // model samples at each handshake
  logic [15:0] log16[$];
  int          logch[$];
  bit          saw_done, saw_fu;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_count = 0;
    m_rem   = 0;
    m_bps   = 1;
    m_nch   = 1;
    m_bytes.delete();
  endtask

  // Compare outputs against the model, then advance the model over the coming edge.
  task automatic check();
    bit e_br, e_sv, acc;
    longint v;
    int bd, nc;
    e_br = (m_state == MCollect) || (m_state == MError);
    e_sv = (m_state == MHold);
    cmp("byte_ready", br32, e_br);
    cmp("byte_ready16", br16, e_br);
    cmp("sample_valid", sv32, e_sv);
    cmp("sample_valid16", sv16, e_sv);
    cmp("done", dn32, m_state == MDone);
    cmp("done16", dn16, m_state == MDone);
    cmp("format_unsupported", fu32, m_state == MError);
    cmp("format_unsupported16", fu16, m_state == MError);
    cmp("sample_count", sc32, m_count);
    cmp("sample_count16", sc16, m_count);
    if (e_sv) begin
      cmp("sample_out", so32, m_out32);
      cmp("sample_out16", so16, m_out16);
      cmp("sample_channel", ch32, m_count % m_nch);
      cmp("sample_channel16", ch16, m_count % m_nch);
    end
    if (dn32) saw_done = 1'b1;
    if (fu32) saw_fu = 1'b1;

    acc = e_br && byte_valid;
    if (acc && feed.size() > 0) void'(feed.pop_front());

    case (m_state)
      MIdle: if (data_start) begin
        bd = int'(bit_depth);
        nc = int'(num_channels);
        m_count = 0;
        m_bytes.delete();
        m_rem = int'(data_bytes);
        if (!(bd == 8 || bd == 16 || bd == 24 || bd == 32) || nc < 1 || nc > 16)
          m_state = MError;
        else begin
          m_bps = bd / 8;
          m_nch = nc;
          m_state = (data_bytes == 0) ? MDone : MCollect;
        end
      end
      MCollect: begin
        if (!data_start) begin
          m_bytes.delete();
          m_state = MIdle;
        end else if (acc) begin
          m_bytes.push_back(byte_in);
          m_rem--;
          if (m_bytes.size() == m_bps) begin
            v = 0;
            for (int i = 0; i < m_bps; i++) v |= longint'(m_bytes[i]) << (8 * i);
            if (m_bps == 1) v ^= 64'h80;
            v = v << (32 - 8 * m_bps);
            m_out32 = v[31:0];
            m_out16 = v[31:16];
            m_bytes.delete();
            m_state = MHold;
          end else if (m_rem == 0) begin
            m_bytes.delete();
            m_state = MDone;
          end
        end
      end
      MHold: begin
        if (sample_ready) begin
          log32.push_back(m_out32);
          log16.push_back(m_out16);
          logch.push_back(m_count % m_nch);
          m_count++;
        end
        if (!data_start) m_state = MIdle;
        else if (sample_ready) m_state = (m_rem == 0) ? MDone : MCollect;
      end
      MDone:  if (!data_start) m_state = MIdle;
      MError: if (!data_start) m_state = MIdle;
      default: m_state = MIdle;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int pv, input int pr);
    byte_valid   = (feed.size() > 0) && ($urandom_range(99) < pv);
    byte_in      = (feed.size() > 0) ? feed[0] : 8'($urandom);
    sample_ready = ($urandom_range(99) < pr);
    step();
  endtask

  task automatic clear_logs();
    log32.delete();
    log16.delete();
    logch.delete();
    saw_done = 1'b0;
    saw_fu   = 1'b0;
  endtask

  // One data phase; the caller fills feed first. Ends on done, after err_cycles
  // in the error state, or at abort_at cycles; then data_start drops.
  task automatic run_phase(input int bd, input int nc, input int db, input int abort_at,
                           input int pv, input int pr, input int err_cycles);
    int cyc;
    bit fin;
    bit_depth = 16'(bd);
    num_channels = 16'(nc);
    data_bytes = 32'(db);
    data_start = 1'b1;
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      if (cyc > 0) begin
        // Header fields are don't-care after the capture cycle.
        bit_depth    = 16'($urandom);
        num_channels = 16'($urandom);
        data_bytes   = $urandom;
      end
      drive(pv, pr);
      cyc++;
      if (m_state == MDone) fin = 1'b1;
      else if (m_state == MError && cyc >= err_cycles) fin = 1'b1;
      else if (abort_at > 0 && cyc == abort_at) fin = 1'b1;
      else if (cyc >= 3000) begin
        cmp("phase_timeout", cyc, 0);
        fin = 1'b1;
      end
    end
    data_start = 1'b0;
    drive(pv, pr);
    drive(pv, pr);
  endtask

  initial begin
    int bds[8] = '{8, 16, 24, 32, 8, 16, 12, 0};
    int cyc;
    rst_n = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    data_start = 1'b0;
    bit_depth = 16'd16;
    num_channels = 16'd1;
    data_bytes = 32'd0;
    sample_ready = 1'b0;
    model_reset();
    clear_logs();
    #1;
    cmp("reset_sample_valid", sv32, 0);
    cmp("reset_byte_ready", br32, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0);

    // 16-bit mono
    clear_logs();
    feed = '{8'h34, 8'h12, 8'hCD, 8'hAB};
    run_phase(16, 1, 4, 0, 100, 100, 0);
    cmp("t1_nsamples", log32.size(), 2);
    cmp("t1_s0", log32[0], 32'h12340000);
    cmp("t1_s1", log32[1], 32'hABCD0000);
    cmp("t1_ch1", logch[1], 0);
    cmp("t1_done_seen", saw_done, 1);
    cmp("t1_count_held", sc32, 2);

    // 8-bit stereo, odd byte count
    clear_logs();
    feed = '{8'h00, 8'hFF, 8'h80};
    run_phase(8, 2, 3, 0, 100, 100, 0);
    cmp("t2_nsamples", log32.size(), 3);
    cmp("t2_s0", log32[0], 32'h80000000);
    cmp("t2_s1", log32[1], 32'h7F000000);
    cmp("t2_s2", log32[2], 32'h00000000);
    cmp("t2_ch", {logch[0][3:0], logch[1][3:0], logch[2][3:0]}, 12'h010);
    cmp("t2_done_seen", saw_done, 1);

    // 24-bit with a five-cycle stall
    clear_logs();
    feed = '{8'h56, 8'h34, 8'h12};
    bit_depth = 16'd24;
    num_channels = 16'd1;
    data_bytes = 32'd3;
    data_start = 1'b1;
    cyc = 0;
    while (m_state != MHold && cyc < 20) begin
      drive(100, 0);
      cyc++;
    end
    cmp("t3_reached_hold", m_state, MHold);
    for (int i = 0; i < 5; i++) drive(100, 0);
    cmp("t3_no_early_handshake", log16.size(), 0);
    drive(100, 100);
    cmp("t3_s16", log16[0], 16'h1234);
    cmp("t3_s32", log32[0], 32'h12345600);
    cyc = 0;
    while (m_state != MDone && cyc < 20) begin
      drive(100, 100);
      cyc++;
    end
    data_start = 1'b0;
    drive(100, 100);
    drive(100, 100);

    // 16-bit mono with a trailing partial sample
    clear_logs();
    feed = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_phase(16, 1, 5, 0, 100, 100, 0);
    cmp("t4_nsamples", log32.size(), 2);
    cmp("t4_s1", log32[1], 32'h04030000);
    cmp("t4_feed_drained", feed.size(), 0);
    cmp("t4_done_seen", saw_done, 1);
    cmp("t4_done_cleared", dn32, 0);
    cmp("t4_count_held", sc32, 2);

    // Unsupported formats swallow bytes and produce nothing
    clear_logs();
    for (int i = 0; i < 10; i++) feed.push_back(8'($urandom));
    run_phase(12, 1, 100, 0, 100, 100, 14);
    cmp("t5_feed_drained", feed.size(), 0);
    cmp("t5_fu_seen", saw_fu, 1);
    cmp("t5_nsamples", log32.size(), 0);
    clear_logs();
    for (int i = 0; i < 10; i++) feed.push_back(8'($urandom));
    run_phase(16, 0, 100, 0, 100, 100, 14);
    cmp("t5b_feed_drained", feed.size(), 0);
    cmp("t5b_fu_seen", saw_fu, 1);
    cmp("t5b_nsamples", log32.size(), 0);

    // Asynchronous reset while holding a sample
    clear_logs();
    feed = '{8'h11, 8'h22, 8'h33, 8'h44};
    bit_depth = 16'd16;
    num_channels = 16'd2;
    data_bytes = 32'd4;
    data_start = 1'b1;
    cyc = 0;
    while (m_state != MHold && cyc < 20) begin
      drive(100, 0);
      cyc++;
    end
    cmp("t6_in_hold", sv32, 1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("t6_rst_byte_ready", br32, 0);
    cmp("t6_rst_sample_valid", sv32, 0);
    cmp("t6_rst_sample_out", so32, 0);
    cmp("t6_rst_sample_out16", so16, 0);
    cmp("t6_rst_channel", ch32, 0);
    cmp("t6_rst_fu", fu32, 0);
    cmp("t6_rst_done", dn32, 0);
    cmp("t6_rst_count", sc32, 0);
    model_reset();
    data_start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(100, 100);
    clear_logs();
    feed = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_phase(16, 2, 4, 0, 100, 100, 0);
    cmp("t6_after_s0", log32[0], 32'hBEEF0000);
    cmp("t6_after_s1", log32[1], 32'hDEAD0000);

    // Randomized phases
    for (int p = 0; p < 60; p++) begin
      int bd, nc, db, ab;
      bd = bds[$urandom_range(7)];
      nc = ($urandom_range(9) == 0) ? int'($urandom_range(20)) : int'($urandom_range(4, 1));
      db = $urandom_range(40);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(30, 1)) : 0;
      feed.delete();
      for (int i = 0; i < db + int'($urandom_range(3)); i++) feed.push_back(8'($urandom));
      run_phase(bd, nc, db, ab, $urandom_range(100, 40), $urandom_range(100, 30), 12);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
